// File: rtl/fadd_arb_pkg.sv
// Shared types and constants for the fadd arbiter slice.
// Holds the fadd latency, the default tag width, the in-flight record
// carried down the response pipe, and a wrap-around increment helper.
package fadd_arb_pkg;

    // Pipeline depth of the shared fadd unit (operand edge to result).
    localparam int FADD_LAT  = 2;
    // Default destination tag width.
    localparam int DEF_TAG_W = 6;
    // Width of the id field; covers up to 8 requesters.
    localparam int ID_FIELD_W = 3;

    // One in-flight operation: valid bit, issuing requester, destination tag.
    typedef struct packed {
        logic                  v;
        logic [ID_FIELD_W-1:0] id;
        logic [DEF_TAG_W-1:0]  tag;
    } inflight_t;

    // (i + 1) mod n without a divider; i is always < n.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 == n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/fadd_arbiter_if.sv
// Bus bundle between the requesters, the shared fadd unit and the arbiter.
//
// Handshake: a requester raises req_valid[i] and holds req_x1/req_x2/req_tag
// slice i stable until it sees req_ready[i]=1 in the same cycle; the op is
// transferred on the rising edge where req_valid[i] & req_ready[i] is true.
// req_ready may depend combinationally on req_valid. Responses (rsp_*) have
// no backpressure: the consumer must take them in the cycle rsp_valid=1.
interface fadd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 6
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*32-1:0]    req_x1;
    logic [NREQ*32-1:0]    req_x2;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic                  flush;
    logic [31:0]           fadd_x1;
    logic [31:0]           fadd_x2;
    logic [31:0]           fadd_y;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_y;

    // Arbiter side.
    modport slave (
        input  req_valid, req_x1, req_x2, req_tag, flush, fadd_y,
        output req_ready, fadd_x1, fadd_x2, rsp_valid, rsp_id, rsp_tag, rsp_y
    );

    // Requester / fadd / consumer side.
    modport master (
        output req_valid, req_x1, req_x2, req_tag, flush, fadd_y,
        input  req_ready, fadd_x1, fadd_x2, rsp_valid, rsp_id, rsp_tag, rsp_y
    );

endinterface

// File: rtl/fadd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr with wrap-around and grants the first set
// request; en=0 suppresses any grant. Reused for other issue arbitration.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    any
);
    localparam int ID_W = $clog2(NREQ);

    int idx;

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (en && !any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd unit among NREQ requesters.
// Round-robin issue of one op per cycle, operand mux to the fadd, and a
// LAT-deep in-flight pipe that tags each result with requester id and tag.
// Optional build macro FADD_ARB_PERF_EN adds issue/conflict counters;
// without it both perf ports read zero and no counter flops exist.
module fadd_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = DEF_TAG_W,
    parameter int LAT   = FADD_LAT
) (
    input  logic                    clk,
    input  logic                    rstn,
    fadd_arbiter_if.slave           bus,
    output logic [31:0]             perf_issue,
    output logic [31:0]             perf_conflict,
    output logic [$clog2(NREQ)-1:0] dbg_ptr
);
    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]  ptr_q;
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic             accept;
    logic [31:0]      mux_x1;
    logic [31:0]      mux_x2;
    logic [TAG_W-1:0] mux_tag;
    inflight_t        stage0_d;
    inflight_t        pipe_q [LAT];

    // Flush blocks issue in the same cycle it is asserted.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .en       (!bus.flush),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    assign bus.req_ready = grant;
    assign accept        = grant_any;
    assign dbg_ptr       = ptr_q;

    // Route the granted requester's operands and tag; zeros when idle.
    always_comb begin
        mux_x1  = '0;
        mux_x2  = '0;
        mux_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mux_x1  = bus.req_x1[32*i +: 32];
                mux_x2  = bus.req_x2[32*i +: 32];
                mux_tag = bus.req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    assign bus.fadd_x1 = mux_x1;
    assign bus.fadd_x2 = mux_x2;

    // Pointer moves just past the winner on acceptance, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ID_W'(wrap_inc(int'(grant_id), NREQ));
        end
    end

    // Record entering the in-flight pipe this cycle.
    always_comb begin
        stage0_d     = '0;
        stage0_d.v   = accept;
        stage0_d.id  = ID_FIELD_W'(grant_id);
        stage0_d.tag = DEF_TAG_W'(mux_tag);
    end

    // Shift pipe mirroring the fadd depth; flush drops every valid bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k].v <= 1'b0;
            end
        end else begin
            pipe_q[0] <= stage0_d;
            for (int k = 1; k < LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign bus.rsp_valid = pipe_q[LAT-1].v;
    assign bus.rsp_id    = ID_W'(pipe_q[LAT-1].id);
    assign bus.rsp_tag   = TAG_W'(pipe_q[LAT-1].tag);
    assign bus.rsp_y     = bus.fadd_y;

`ifdef FADD_ARB_PERF_EN
    logic        multi_req;
    logic [31:0] issue_q;
    logic [31:0] conflict_q;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_req = |(bus.req_valid & (bus.req_valid - NREQ'(1)));

    // Free-running wrap-around counters of issues and contended cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (accept) begin
                issue_q <= issue_q + 32'd1;
            end
            if (multi_req && !bus.flush) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    assign perf_issue    = issue_q;
    assign perf_conflict = conflict_q;
`else
    assign perf_issue    = 32'h0;
    assign perf_conflict = 32'h0;
`endif

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter: an arbitration vector table on a
// 4-requester instance plus hand-written multi-cycle sequences (single op,
// back-to-back ordering, flush, reset mid-flight) and a 3-requester wrap.
module tb_fadd_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    fadd_arbiter_if #(.NREQ(4), .TAG_W(6)) bus4 ();
    fadd_arbiter_if #(.NREQ(3), .TAG_W(6)) bus3 ();

    logic [31:0] perf_issue4, perf_conflict4, perf_issue3, perf_conflict3;
    logic [1:0]  ptr4, ptr3;

    fadd_arbiter #(.NREQ(4), .TAG_W(6), .LAT(2)) dut4 (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus4),
        .perf_issue    (perf_issue4),
        .perf_conflict (perf_conflict4),
        .dbg_ptr       (ptr4)
    );

    fadd_arbiter #(.NREQ(3), .TAG_W(6), .LAT(2)) dut3 (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus3),
        .perf_issue    (perf_issue3),
        .perf_conflict (perf_conflict3),
        .dbg_ptr       (ptr3)
    );

    // fadd model: known sums for the test operands, XOR otherwise.
    function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3FC00000, 32'hBF000000}: return 32'h3F800000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                      return a ^ b;
        endcase
    endfunction

    logic [31:0] fadd_s1, fadd_s2;
    always @(posedge clk) begin
        fadd_s1 <= fadd_ref(bus4.fadd_x1, bus4.fadd_x2);
        fadd_s2 <= fadd_s1;
    end
    assign bus4.fadd_y = fadd_s2;
    assign bus3.fadd_y = 32'h0;

`ifdef FADD_ARB_PERF_EN
    localparam int EXP_ISSUE = 13;
    localparam int EXP_CONF  = 11;
    localparam int EXP_ISSUE8 = 8;
    localparam int EXP_CONF8  = 8;
`else
    localparam int EXP_ISSUE = 0;
    localparam int EXP_CONF  = 0;
    localparam int EXP_ISSUE8 = 0;
    localparam int EXP_CONF8  = 0;
`endif

    typedef struct {
        logic [3:0] valid;
        logic       flush;
        logic [3:0] exp_ready;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [15];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus4.req_valid = '0;
        bus4.flush     = 1'b0;
        bus3.req_valid = '0;
        bus3.flush     = 1'b0;
    endtask

    task automatic set_op4(input int i, input logic [31:0] x1, input logic [31:0] x2, input logic [5:0] tag);
        bus4.req_x1[32*i +: 32] = x1;
        bus4.req_x2[32*i +: 32] = x2;
        bus4.req_tag[6*i +: 6]  = tag;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_x1, exp_x2;

        // valid, flush, expected ready, expected pointer during the cycle
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 2'd2};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 2'd1};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[9]  = '{4'b0110, 1'b1, 4'b0000, 2'd0};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 2'd0};
        vecs[11] = '{4'b0011, 1'b0, 4'b0001, 2'd3};
        vecs[12] = '{4'b1001, 1'b0, 4'b1000, 2'd1};
        vecs[13] = '{4'b1010, 1'b0, 4'b0010, 2'd0};
        vecs[14] = '{4'b0010, 1'b0, 4'b0010, 2'd2};

        bus4.req_x1 = '0; bus4.req_x2 = '0; bus4.req_tag = '0;
        bus3.req_x1 = '0; bus3.req_x2 = '0; bus3.req_tag = '0;
        do_reset();

        // Reset state.
        #1;
        chk("reset rsp_valid", 32'(bus4.rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(bus4.rsp_id), 32'd0);
        chk("reset rsp_tag", 32'(bus4.rsp_tag), 32'd0);
        chk("reset ptr", 32'(ptr4), 32'd0);
        chk("reset perf_issue", perf_issue4, 32'd0);
        chk("reset perf_conflict", perf_conflict4, 32'd0);
        chk("reset req_ready", 32'(bus4.req_ready), 32'd0);
        chk("reset fadd_x1", bus4.fadd_x1, 32'd0);
        chk("reset rsp_valid n3", 32'(bus3.rsp_valid), 32'd0);

        // Arbitration table with distinct per-requester operands.
        for (int i = 0; i < 4; i++) begin
            set_op4(i, 32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 6'(10 + i));
        end
        for (int v = 0; v < 15; v++) begin
            bus4.req_valid = vecs[v].valid;
            bus4.flush     = vecs[v].flush;
            #1;
            exp_x1 = 32'h0;
            exp_x2 = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (vecs[v].exp_ready[j]) begin
                    exp_x1 = 32'h1111_0000 + 32'(j);
                    exp_x2 = 32'h2222_0000 + 32'(j);
                end
            end
            chk($sformatf("vec%0d ready", v), 32'(bus4.req_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("vec%0d ptr", v), 32'(ptr4), 32'(vecs[v].exp_ptr));
            chk($sformatf("vec%0d fadd_x1", v), bus4.fadd_x1, exp_x1);
            chk($sformatf("vec%0d fadd_x2", v), bus4.fadd_x2, exp_x2);
            step();
            if (v == 7) begin
                chk("rr8 perf_issue", perf_issue4, 32'(EXP_ISSUE8));
                chk("rr8 perf_conflict", perf_conflict4, 32'(EXP_CONF8));
            end
        end
        idle();
        #1;
        chk("table perf_issue", perf_issue4, 32'(EXP_ISSUE));
        chk("table perf_conflict", perf_conflict4, 32'(EXP_CONF));

        // Single op from requester 0, response two cycles after issue.
        do_reset();
        set_op4(0, 32'h3F800000, 32'h40000000, 6'd5);
        bus4.req_valid = 4'b0001;
        #1;
        chk("single ready", 32'(bus4.req_ready), 32'h1);
        step();
        idle();
        #1;
        chk("single rsp early", 32'(bus4.rsp_valid), 32'd0);
        step();
        chk("single rsp_valid", 32'(bus4.rsp_valid), 32'd1);
        chk("single rsp_id", 32'(bus4.rsp_id), 32'd0);
        chk("single rsp_tag", 32'(bus4.rsp_tag), 32'd5);
        chk("single rsp_y", bus4.rsp_y, 32'h40400000);
        step();
        chk("single rsp after", 32'(bus4.rsp_valid), 32'd0);

        // Back-to-back issues from requesters 1 then 2.
        do_reset();
        set_op4(1, 32'h3FC00000, 32'hBF000000, 6'd7);
        set_op4(2, 32'h40000000, 32'h40000000, 6'd9);
        bus4.req_valid = 4'b0010;
        #1;
        chk("b2b ready1", 32'(bus4.req_ready), 32'h2);
        step();
        bus4.req_valid = 4'b0100;
        #1;
        chk("b2b ready2", 32'(bus4.req_ready), 32'h4);
        step();
        idle();
        #1;
        chk("b2b rsp0 valid", 32'(bus4.rsp_valid), 32'd1);
        chk("b2b rsp0 id", 32'(bus4.rsp_id), 32'd1);
        chk("b2b rsp0 tag", 32'(bus4.rsp_tag), 32'd7);
        chk("b2b rsp0 y", bus4.rsp_y, 32'h3F800000);
        step();
        chk("b2b rsp1 valid", 32'(bus4.rsp_valid), 32'd1);
        chk("b2b rsp1 id", 32'(bus4.rsp_id), 32'd2);
        chk("b2b rsp1 tag", 32'(bus4.rsp_tag), 32'd9);
        chk("b2b rsp1 y", bus4.rsp_y, 32'h40800000);
        step();
        chk("b2b rsp done", 32'(bus4.rsp_valid), 32'd0);

        // Flush after two issues: no grant, pointer holds, in-flight killed.
        do_reset();
        bus4.req_valid = 4'b0001;
        step();
        bus4.req_valid = 4'b0010;
        step();
        bus4.req_valid = 4'b0100;
        bus4.flush     = 1'b1;
        #1;
        chk("flush ready", 32'(bus4.req_ready), 32'd0);
        chk("flush ptr", 32'(ptr4), 32'd2);
        step();
        idle();
        #1;
        chk("flush ptr held", 32'(ptr4), 32'd2);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("flush no rsp c%0d", c), 32'(bus4.rsp_valid), 32'd0);
            step();
        end

        // Reset one cycle after an issue drops the op and clears the pointer.
        do_reset();
        set_op4(3, 32'h40000000, 32'h40000000, 6'd3);
        bus4.req_valid = 4'b0001;
        step();
        rstn = 1'b0;
        idle();
        step();
        chk("rst mid rsp", 32'(bus4.rsp_valid), 32'd0);
        chk("rst mid ptr", 32'(ptr4), 32'd0);
        step();
        chk("rst hold rsp", 32'(bus4.rsp_valid), 32'd0);
        rstn = 1'b1;
        bus4.req_valid = 4'b1000;
        #1;
        chk("rst req3 ready", 32'(bus4.req_ready), 32'h8);
        step();
        idle();
        #1;
        chk("rst req3 ptr", 32'(ptr4), 32'd0);
        chk("rst req3 no rsp yet", 32'(bus4.rsp_valid), 32'd0);
        step();
        chk("rst req3 rsp valid", 32'(bus4.rsp_valid), 32'd1);
        chk("rst req3 rsp id", 32'(bus4.rsp_id), 32'd3);
        chk("rst req3 rsp y", bus4.rsp_y, 32'h40800000);

        // Non-power-of-two wrap on the 3-requester instance.
        chk("n3 ptr start", 32'(ptr3), 32'd0);
        bus3.req_valid = 3'b100;
        #1;
        chk("n3 ready req2", 32'(bus3.req_ready), 32'h4);
        step();
        bus3.req_valid = 3'b001;
        #1;
        chk("n3 ptr wrapped", 32'(ptr3), 32'd0);
        chk("n3 ready req0", 32'(bus3.req_ready), 32'h1);
        step();
        idle();
        #1;
        chk("n3 ptr after req0", 32'(ptr3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
